rate_lock_controller: RTL and testbench
=======================================

// Module: rate_lock_controller
// PURPOSE
//  Sequences clock/data rate recovery: acquires a lock rate from measured edge-to-edge periods,
//  holds it with tolerance checks, manages pause/resume for pausable modes, and drives the
//  clear/enable controls of the half-rate recovery and drift-tracking datapaths.
//  Sits between the edge detector/period counter and the drift tracker inside rate recovery.
// PARAMETERS
//  RATE_W      16  width of measured periods, target rate and tolerance
//  ACQ_COUNT    4  consecutive in-window samples required to declare lock (>=2)
//  MAX_MISSES   3  consecutive out-of-window samples in LOCKED before lock is dropped (>=1)
//  PAUSE_W     16  width of the idle (no-edge) cycle counter
// PORTS
//  sys_dom_i.clk             in   1       system clock
//  sys_dom_i.rst             in   1       asynchronous, active-high reset
//  enable_i                  in   1       controller enable
//  mode_i                    in   3       recovery_mode_e (SINGLE/DIF/QUAD x CONTINUOUS/PAUSABLE)
//  any_valid_edge_i          in   1       qualified edge strobe from edge detection
//  rate_valid_i              in   1       measured_rate_i is a new sample this cycle
//  measured_rate_i           in   RATE_W  edge-to-edge period in sys clocks
//  tolerance_i               in   RATE_W  allowed +/- skew around target
//  pause_timeout_i           in   PAUSE_W idle cycles before PAUSED (pausable) or lock loss (continuous)
//  drift_acc_overflow_i      in   1       from drift tracking: forces lock loss
//  inverse_drift_violation_i in   1       from drift tracking: forces lock loss
//  locked_o                  out  1       target_rate_o is valid and being tracked
//  paused_o                  out  1       in PAUSED state
//  target_rate_o             out  RATE_W  locked (half-)rate
//  accumulator_en_o          out  1       drift accumulator enable (=locked_o & ~paused_o)
//  clear_state_o             out  1       one-cycle pulse: clear downstream recovery/drift state
//  violation_o               out  1       one-cycle pulse: locked sample outside window
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; target, candidate, counters 0.
//  Effective sample s = measured_rate_i for SINGLE_*, measured_rate_i>>1 for DIF_*/QUAD_*.
//  Window: lo = sat0(ref - tolerance_i), hi = satmax(ref + tolerance_i), RATE_W+1-bit math;
//  in-window iff lo <= s <= hi (inclusive).
//  IDLE: enable_i=1 -> latch mode_i, ACQUIRE. mode_i is ignored outside IDLE.
//  ACQUIRE: first sample -> candidate=s, hit=1. In-window sample -> hit++; hit==ACQ_COUNT ->
//   target=candidate, LOCKED, locked_o=1 next cycle. Out-of-window -> candidate=s, hit=1.
//  LOCKED: in-window sample clears miss count; out-of-window -> violation_o pulse, miss++;
//   miss==MAX_MISSES -> lock loss. PAUSABLE modes: sample with rate_min<=s<lo (clock sped
//   up after pause) retargets target=s without violation.
//  Idle counter: clears on any_valid_edge_i, else saturating increment in LOCKED.
//   count>=pause_timeout_i: PAUSABLE -> PAUSED; CONTINUOUS -> lock loss.
//  PAUSED: paused_o=1, target held. any_valid_edge_i -> LOCKED; first rate sample after
//   resume is discarded (spans the pause).
//  Lock loss: clear_state_o pulse, locked_o=0, miss/hit/idle=0, -> ACQUIRE.
//  Priority per cycle: enable_i=0 > drift_acc_overflow_i/inverse_drift_violation_i > idle
//   timeout > sample check. enable_i=0 in any non-IDLE state -> IDLE with clear_state_o pulse.
//  Drift faults act only in LOCKED/PAUSED; ignored in IDLE/ACQUIRE.
//  pause_timeout_i==0: timeout never fires. tolerance_i==0: exact-match window.
//  Latency: decision registered; outputs change the cycle after the causing input.
// CONFIGURATION
//  RATE_LOCK_STATS_EN defined: adds outputs lock_loss_count_o[15:0] and violation_count_o[15:0],
//  saturating, cleared only by reset. Undefined: ports and counters absent; behaviour identical.
// STRUCTURE
//  clks_alot_pkg: recovery_mode_e, lock_state_e {IDLE,ACQUIRE,LOCKED,PAUSED}, is_pausable()/
//  is_half_rate() helper functions.
//  Sub-module rate_window_check: combinational saturating lo/hi bounds and in-window compare,
//  instantiated once (ACQUIRE uses candidate as ref, LOCKED uses target).
// TESTING
//  SINGLE_CONTINUOUS, tol=2, samples 100,101,99,100 -> locked_o=1, target_rate_o=100.
//  DIF_CONTINUOUS, samples 200x4 -> target 100; sample 120 x3 -> 3 violation_o, clear_state_o, ACQUIRE.
//  SINGLE_PAUSABLE locked at 50, timeout=20, no edges 20 cycles -> paused_o=1; edge -> LOCKED, next sample ignored.
//  SINGLE_CONTINUOUS locked, timeout=20, no edges -> clear_state_o pulse, locked_o=0.
//  Locked + drift_acc_overflow_i same cycle as in-window sample -> lock loss wins.
//  Reset asserted mid-LOCKED -> all outputs 0 immediately; enable_i=0 mid-ACQUIRE -> IDLE + clear pulse.

Source files
------------

// File: rtl/clks_alot_pkg.sv
// Shared types and mode helpers for the rate-lock controller and its window checker.
package clks_alot_pkg;

  typedef enum logic [2:0] {
    SINGLE_CONTINUOUS = 3'd0,
    SINGLE_PAUSABLE   = 3'd1,
    DIF_CONTINUOUS    = 3'd2,
    DIF_PAUSABLE      = 3'd3,
    QUAD_CONTINUOUS   = 3'd4,
    QUAD_PAUSABLE     = 3'd5
  } recovery_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    PAUSED  = 2'd3
  } lock_state_e;

  function automatic logic is_pausable(recovery_mode_e m);
    return m[0];
  endfunction

  function automatic logic is_half_rate(recovery_mode_e m);
    return m[2:1] != 2'b00;
  endfunction

endpackage

// File: rtl/rate_window_check.sv
// Combinational +/- tolerance window around a reference rate, saturating at 0 and all-ones.
module rate_window_check #(
  parameter int unsigned RATE_W = 16
) (
  input  logic [RATE_W-1:0] ref_rate,
  input  logic [RATE_W-1:0] tolerance,
  input  logic [RATE_W-1:0] sample,
  output logic [RATE_W-1:0] lo,
  output logic              in_window
);

  logic [RATE_W:0]   lo_ext;
  logic [RATE_W:0]   hi_ext;
  logic [RATE_W-1:0] hi;

  always_comb begin
    lo_ext    = {1'b0, ref_rate} - {1'b0, tolerance};
    hi_ext    = {1'b0, ref_rate} + {1'b0, tolerance};
    lo        = lo_ext[RATE_W] ? '0 : lo_ext[RATE_W-1:0];
    hi        = hi_ext[RATE_W] ? '1 : hi_ext[RATE_W-1:0];
    in_window = (sample >= lo) && (sample <= hi);
  end

endmodule

// File: rtl/rate_lock_controller.sv
// Rate acquisition / lock / pause sequencer for rate recovery.
// Optional RATE_LOCK_STATS_EN adds saturating lock-loss and violation counters.
module rate_lock_controller
  import clks_alot_pkg::*;
#(
  parameter int unsigned RATE_W     = 16,
  parameter int unsigned ACQ_COUNT  = 4,
  parameter int unsigned MAX_MISSES = 3,
  parameter int unsigned PAUSE_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic [2:0]         mode_i,
  input  logic               any_valid_edge_i,
  input  logic               rate_valid_i,
  input  logic [RATE_W-1:0]  measured_rate_i,
  input  logic [RATE_W-1:0]  tolerance_i,
  input  logic [PAUSE_W-1:0] pause_timeout_i,
  input  logic               drift_acc_overflow_i,
  input  logic               inverse_drift_violation_i,
  output logic               locked_o,
  output logic               paused_o,
  output logic [RATE_W-1:0]  target_rate_o,
  output logic               accumulator_en_o,
  output logic               clear_state_o,
  output logic               violation_o
`ifdef RATE_LOCK_STATS_EN
  ,
  output logic [15:0]        lock_loss_count_o,
  output logic [15:0]        violation_count_o
`endif
);

  localparam int unsigned HIT_W  = $clog2(ACQ_COUNT + 1);
  localparam int unsigned MISS_W = $clog2(MAX_MISSES + 1);
  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(ACQ_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MAX_MISSES - 1);

  lock_state_e        state, state_d;
  recovery_mode_e     mode_q, mode_d;
  logic [RATE_W-1:0]  target, target_d, candidate, cand_d;
  logic [HIT_W-1:0]   hit, hit_d;
  logic [MISS_W-1:0]  miss, miss_d;
  logic [PAUSE_W-1:0] idle, idle_d;
  logic               skip, skip_d;
  logic               clear_d, viol_d, lock_loss;

  logic [RATE_W-1:0]  sample, ref_rate, lo;
  logic               in_window, drift_fault, timeout;

  assign sample      = is_half_rate(mode_q) ? {1'b0, measured_rate_i[RATE_W-1:1]} : measured_rate_i;
  assign ref_rate    = (state == LOCKED) ? target : candidate;
  assign drift_fault = drift_acc_overflow_i | inverse_drift_violation_i;
  assign timeout     = (pause_timeout_i != '0) && (idle >= pause_timeout_i) && !any_valid_edge_i;

  rate_window_check #(.RATE_W(RATE_W)) u_window (
    .ref_rate  (ref_rate),
    .tolerance (tolerance_i),
    .sample    (sample),
    .lo        (lo),
    .in_window (in_window)
  );

  always_comb begin
    state_d   = state;
    mode_d    = mode_q;
    target_d  = target;
    cand_d    = candidate;
    hit_d     = hit;
    miss_d    = miss;
    skip_d    = skip;
    clear_d   = 1'b0;
    viol_d    = 1'b0;
    lock_loss = 1'b0;
    idle_d    = '0;
    if (state == LOCKED && !any_valid_edge_i)
      idle_d = (idle == '1) ? idle : idle + 1'b1;

    if (state != IDLE && !enable_i) begin
      state_d = IDLE;
      clear_d = 1'b1;
      hit_d   = '0;
      miss_d  = '0;
      skip_d  = 1'b0;
      idle_d  = '0;
    end else begin
      case (state)
        IDLE: if (enable_i) begin
          mode_d  = recovery_mode_e'(mode_i);
          state_d = ACQUIRE;
          hit_d   = '0;
        end
        ACQUIRE: if (rate_valid_i) begin
          if (hit == '0 || !in_window) begin
            cand_d = sample;
            hit_d  = HIT_W'(1);
          end else if (hit == HIT_LAST) begin
            target_d = candidate;
            state_d  = LOCKED;
            hit_d    = '0;
            miss_d   = '0;
            skip_d   = 1'b0;
          end else begin
            hit_d = hit + 1'b1;
          end
        end
        LOCKED: begin
          if (drift_fault) begin
            lock_loss = 1'b1;
          end else if (timeout) begin
            if (is_pausable(mode_q)) state_d = PAUSED;
            else                     lock_loss = 1'b1;
          end else if (rate_valid_i) begin
            if (skip) begin
              skip_d = 1'b0;
            end else if (in_window) begin
              miss_d = '0;
            end else if (is_pausable(mode_q) && sample != '0 && sample < lo) begin
              // Faster clock after a pause: follow it instead of counting a miss.
              target_d = sample;
              miss_d   = '0;
            end else begin
              viol_d = 1'b1;
              if (miss == MISS_LAST) lock_loss = 1'b1;
              else                   miss_d = miss + 1'b1;
            end
          end
        end
        PAUSED: begin
          if (drift_fault) begin
            lock_loss = 1'b1;
          end else if (any_valid_edge_i) begin
            state_d = LOCKED;
            skip_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (lock_loss) begin
      state_d = ACQUIRE;
      clear_d = 1'b1;
      hit_d   = '0;
      miss_d  = '0;
      idle_d  = '0;
      skip_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mode_q        <= SINGLE_CONTINUOUS;
      target        <= '0;
      candidate     <= '0;
      hit           <= '0;
      miss          <= '0;
      idle          <= '0;
      skip          <= 1'b0;
      clear_state_o <= 1'b0;
      violation_o   <= 1'b0;
    end else begin
      state         <= state_d;
      mode_q        <= mode_d;
      target        <= target_d;
      candidate     <= cand_d;
      hit           <= hit_d;
      miss          <= miss_d;
      idle          <= idle_d;
      skip          <= skip_d;
      clear_state_o <= clear_d;
      violation_o   <= viol_d;
    end
  end

  assign locked_o         = (state == LOCKED) || (state == PAUSED);
  assign paused_o         = (state == PAUSED);
  assign accumulator_en_o = (state == LOCKED);
  assign target_rate_o    = target;

`ifdef RATE_LOCK_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_loss_count_o <= '0;
      violation_count_o <= '0;
    end else begin
      if (lock_loss && lock_loss_count_o != '1) lock_loss_count_o <= lock_loss_count_o + 1'b1;
      if (viol_d && violation_count_o != '1)    violation_count_o <= violation_count_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rate_lock_controller.sv
// Directed self-checking bench for rate_lock_controller (default build).
module tb_rate_lock_controller;
  import clks_alot_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic [2:0]  mode_i = 3'd0;
  logic        any_valid_edge_i = 1'b0;
  logic        rate_valid_i = 1'b0;
  logic [15:0] measured_rate_i = '0;
  logic [15:0] tolerance_i = '0;
  logic [15:0] pause_timeout_i = '0;
  logic        drift_acc_overflow_i = 1'b0;
  logic        inverse_drift_violation_i = 1'b0;
  logic        locked_o, paused_o, accumulator_en_o, clear_state_o, violation_o;
  logic [15:0] target_rate_o;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  rate_lock_controller #(.RATE_W(16), .ACQ_COUNT(4), .MAX_MISSES(3), .PAUSE_W(16)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .enable_i                  (enable_i),
    .mode_i                    (mode_i),
    .any_valid_edge_i          (any_valid_edge_i),
    .rate_valid_i              (rate_valid_i),
    .measured_rate_i           (measured_rate_i),
    .tolerance_i               (tolerance_i),
    .pause_timeout_i           (pause_timeout_i),
    .drift_acc_overflow_i      (drift_acc_overflow_i),
    .inverse_drift_violation_i (inverse_drift_violation_i),
    .locked_o                  (locked_o),
    .paused_o                  (paused_o),
    .target_rate_o             (target_rate_o),
    .accumulator_en_o          (accumulator_en_o),
    .clear_state_o             (clear_state_o),
    .violation_o               (violation_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] v);
    rate_valid_i     = 1'b1;
    any_valid_edge_i = 1'b1;
    measured_rate_i  = v;
    step();
    rate_valid_i     = 1'b0;
    any_valid_edge_i = 1'b0;
  endtask

  task automatic relock(input recovery_mode_e m, input logic [15:0] v, input logic [15:0] tmo);
    enable_i = 1'b0;
    step();
    mode_i          = m;
    tolerance_i     = 16'd2;
    pause_timeout_i = tmo;
    enable_i        = 1'b1;
    step();
    for (int i = 0; i < 4; i++) feed(v);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    tests++; if (locked_o !== 1'b0) begin failed++; $display("FAIL reset_locked got %b exp 0", locked_o); end
    tests++; if (paused_o !== 1'b0) begin failed++; $display("FAIL reset_paused got %b exp 0", paused_o); end
    tests++; if (target_rate_o !== 16'd0) begin failed++; $display("FAIL reset_target got %0d exp 0", target_rate_o); end
    tests++; if ({clear_state_o, violation_o, accumulator_en_o} !== 3'b000) begin failed++; $display("FAIL reset_pulses got %b exp 000", {clear_state_o, violation_o, accumulator_en_o}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_lock();
    mode_i = SINGLE_CONTINUOUS; tolerance_i = 16'd2; pause_timeout_i = '0; enable_i = 1'b1;
    step();
    feed(16'd100); feed(16'd101); feed(16'd99);
    tests++; if (locked_o !== 1'b0) begin failed++; $display("FAIL single_prelock got %b exp 0", locked_o); end
    feed(16'd100);
    tests++; if (locked_o !== 1'b1) begin failed++; $display("FAIL single_locked got %b exp 1", locked_o); end
    tests++; if (target_rate_o !== 16'd100) begin failed++; $display("FAIL single_target got %0d exp 100", target_rate_o); end
    tests++; if (accumulator_en_o !== 1'b1) begin failed++; $display("FAIL single_acc_en got %b exp 1", accumulator_en_o); end
    enable_i = 1'b0;
    step();
    tests++; if (clear_state_o !== 1'b1 || locked_o !== 1'b0) begin failed++; $display("FAIL single_disable clear=%b locked=%b exp 1 0", clear_state_o, locked_o); end
  endtask

  task automatic test_dif_violation();
    relock(DIF_CONTINUOUS, 16'd200, 16'd0);
    tests++; if (locked_o !== 1'b1 || target_rate_o !== 16'd100) begin failed++; $display("FAIL dif_lock locked=%b target=%0d exp 1 100", locked_o, target_rate_o); end
    for (int i = 0; i < 3; i++) begin
      feed(16'd120);
      tests++; if (violation_o !== 1'b1) begin failed++; $display("FAIL dif_viol%0d got %b exp 1", i, violation_o); end
      tests++; if (clear_state_o !== (i == 2)) begin failed++; $display("FAIL dif_clear%0d got %b exp %b", i, clear_state_o, (i == 2)); end
    end
    tests++; if (locked_o !== 1'b0) begin failed++; $display("FAIL dif_lost got %b exp 0", locked_o); end
    step();
    tests++; if (violation_o !== 1'b0 || clear_state_o !== 1'b0) begin failed++; $display("FAIL dif_pulse_end viol=%b clear=%b exp 0 0", violation_o, clear_state_o); end
    for (int i = 0; i < 4; i++) feed(16'd200);
    tests++; if (locked_o !== 1'b1) begin failed++; $display("FAIL dif_reacquire got %b exp 1", locked_o); end
  endtask

  task automatic test_pause();
    relock(SINGLE_PAUSABLE, 16'd50, 16'd20);
    for (int i = 0; i < 20; i++) step();
    tests++; if (paused_o !== 1'b0) begin failed++; $display("FAIL pause_early got %b exp 0", paused_o); end
    step();
    tests++; if (paused_o !== 1'b1 || locked_o !== 1'b1 || accumulator_en_o !== 1'b0) begin failed++; $display("FAIL pause_enter paused=%b locked=%b acc=%b exp 1 1 0", paused_o, locked_o, accumulator_en_o); end
    any_valid_edge_i = 1'b1;
    step();
    any_valid_edge_i = 1'b0;
    tests++; if (paused_o !== 1'b0 || accumulator_en_o !== 1'b1) begin failed++; $display("FAIL pause_resume paused=%b acc=%b exp 0 1", paused_o, accumulator_en_o); end
    feed(16'd30);
    tests++; if (target_rate_o !== 16'd50 || violation_o !== 1'b0) begin failed++; $display("FAIL pause_discard target=%0d viol=%b exp 50 0", target_rate_o, violation_o); end
    feed(16'd40);
    tests++; if (target_rate_o !== 16'd40 || violation_o !== 1'b0) begin failed++; $display("FAIL pause_retarget target=%0d viol=%b exp 40 0", target_rate_o, violation_o); end
    feed(16'd80);
    tests++; if (violation_o !== 1'b1) begin failed++; $display("FAIL pause_above got %b exp 1", violation_o); end
  endtask

  task automatic test_continuous_timeout();
    relock(SINGLE_CONTINUOUS, 16'd50, 16'd20);
    for (int i = 0; i < 20; i++) step();
    tests++; if (locked_o !== 1'b1 || clear_state_o !== 1'b0) begin failed++; $display("FAIL cont_early locked=%b clear=%b exp 1 0", locked_o, clear_state_o); end
    step();
    tests++; if (clear_state_o !== 1'b1 || locked_o !== 1'b0 || paused_o !== 1'b0) begin failed++; $display("FAIL cont_timeout clear=%b locked=%b paused=%b exp 1 0 0", clear_state_o, locked_o, paused_o); end
    step();
    tests++; if (clear_state_o !== 1'b0) begin failed++; $display("FAIL cont_pulse got %b exp 0", clear_state_o); end
  endtask

  task automatic test_drift_priority();
    relock(SINGLE_CONTINUOUS, 16'd50, 16'd0);
    drift_acc_overflow_i = 1'b1;
    feed(16'd50);
    drift_acc_overflow_i = 1'b0;
    tests++; if (clear_state_o !== 1'b1 || locked_o !== 1'b0 || violation_o !== 1'b0) begin failed++; $display("FAIL drift_loss clear=%b locked=%b viol=%b exp 1 0 0", clear_state_o, locked_o, violation_o); end
    inverse_drift_violation_i = 1'b1;
    feed(16'd50);
    inverse_drift_violation_i = 1'b0;
    for (int i = 0; i < 3; i++) feed(16'd50);
    tests++; if (locked_o !== 1'b1 || target_rate_o !== 16'd50) begin failed++; $display("FAIL drift_acq_ignored locked=%b target=%0d exp 1 50", locked_o, target_rate_o); end
  endtask

  task automatic test_window_edges();
    enable_i = 1'b0; step();
    mode_i = SINGLE_CONTINUOUS; tolerance_i = 16'd0; pause_timeout_i = '0; enable_i = 1'b1;
    step();
    feed(16'd70); feed(16'd71); feed(16'd71); feed(16'd71);
    tests++; if (locked_o !== 1'b0) begin failed++; $display("FAIL exact_prelock got %b exp 0", locked_o); end
    feed(16'd71);
    tests++; if (locked_o !== 1'b1 || target_rate_o !== 16'd71) begin failed++; $display("FAIL exact_lock locked=%b target=%0d exp 1 71", locked_o, target_rate_o); end
    enable_i = 1'b0; step();
    tolerance_i = 16'hFFFF; enable_i = 1'b1;
    step();
    feed(16'd5); feed(16'hFFFF); feed(16'd0); feed(16'd7);
    tests++; if (locked_o !== 1'b1 || target_rate_o !== 16'd5) begin failed++; $display("FAIL sat_lock locked=%b target=%0d exp 1 5", locked_o, target_rate_o); end
  endtask

  task automatic test_enable_drop_acquire();
    enable_i = 1'b0; step();
    mode_i = SINGLE_CONTINUOUS; tolerance_i = 16'd2; enable_i = 1'b1;
    step();
    feed(16'd60); feed(16'd60);
    enable_i = 1'b0;
    step();
    tests++; if (clear_state_o !== 1'b1 || locked_o !== 1'b0) begin failed++; $display("FAIL acq_drop clear=%b locked=%b exp 1 0", clear_state_o, locked_o); end
    for (int i = 0; i < 4; i++) feed(16'd60);
    tests++; if (locked_o !== 1'b0 || clear_state_o !== 1'b0) begin failed++; $display("FAIL idle_hold locked=%b clear=%b exp 0 0", locked_o, clear_state_o); end
  endtask

  task automatic test_reset_mid_lock();
    relock(SINGLE_CONTINUOUS, 16'd90, 16'd0);
    tests++; if (locked_o !== 1'b1) begin failed++; $display("FAIL rst_prelock got %b exp 1", locked_o); end
    #2 rst = 1'b1;
    #1;
    tests++; if (locked_o !== 1'b0 || target_rate_o !== 16'd0 || accumulator_en_o !== 1'b0) begin failed++; $display("FAIL rst_async locked=%b target=%0d acc=%b exp 0 0 0", locked_o, target_rate_o, accumulator_en_o); end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_lock();
    test_dif_violation();
    test_pause();
    test_continuous_timeout();
    test_drift_priority();
    test_window_edges();
    test_enable_drop_acquire();
    test_reset_mid_lock();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
